branch_target_predictor: RTL and testbench

Dynamic branch predictor and branch target buffer (BTB) for the 5-stage MIPS pipeline. It replaces static predict-not-taken with a parametrised, direct-mapped table of tagged entries, each holding a target and a saturating direction counter. IF looks it up combinationally to pick the next PC. EX resolves branches and jumps, updates the table, and gets back a mispredict/recover signal for the hazard unit's flush and PC-select logic.

---
 rtl/branch_target_predictor_pkg.sv | 40 ++++
 rtl/branch_target_predictor_sat_counter.sv | 32 +++
 rtl/branch_target_predictor.sv | 135 +++++++++++++
 tb/tb_branch_target_predictor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_target_predictor_pkg.sv
// Shared helpers for the branch target predictor: PC field extraction,
// saturating counter arithmetic and the weakly-taken counter seed.
package branch_target_predictor_pkg;

  localparam int BP_MAX_W   = 64;
  localparam int BP_ENTRIES = 16;
  localparam int BP_ADDR_W  = 32;
  localparam int BP_CTR_W   = 2;
  localparam int BP_STAT_W  = 32;

  function automatic logic [BP_MAX_W-1:0] bp_ctr_init(input int unsigned ctrW);
    return 64'd1 << (ctrW - 32'd1);
  endfunction

  localparam logic [BP_MAX_W-1:0] BP_CTR_INIT = bp_ctr_init(BP_CTR_W);

  function automatic logic [BP_MAX_W-1:0] bp_idx(input logic [BP_MAX_W-1:0] pc,
                                                  input int unsigned idxW);
    return (pc >> 32'd2) & ((64'd1 << idxW) - 64'd1);
  endfunction

  function automatic logic [BP_MAX_W-1:0] bp_tag(input logic [BP_MAX_W-1:0] pc,
                                                  input int unsigned idxW);
    return pc >> (idxW + 32'd2);
  endfunction

  // One step up or down, clamped to [0, 2^w-1] instead of wrapping.
  function automatic logic [BP_MAX_W-1:0] bp_sat_step(input logic [BP_MAX_W-1:0] value,
                                                       input logic up,
                                                       input int unsigned w);
    logic [BP_MAX_W-1:0] maxVal;
    maxVal = (w >= 32'd64) ? {BP_MAX_W{1'b1}} : ((64'd1 << w) - 64'd1);
    if (up) begin
      return (value == maxVal) ? value : value + 64'd1;
    end else begin
      return (value == 64'd0) ? value : value - 64'd1;
    end
  endfunction

endpackage

// File: rtl/branch_target_predictor_sat_counter.sv
// Saturating up/down register with a synchronous load; used for the
// per-entry direction counters and the performance counters.
module branch_target_predictor_sat_counter
  import branch_target_predictor_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadValue,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value
);

  // reset beats load, load beats counting
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= {W{1'b0}};
    end else if (load) begin
      value <= loadValue;
    end else if (inc) begin
      value <= W'(bp_sat_step(BP_MAX_W'(value), 1'b1, W));
    end else if (dec) begin
      value <= W'(bp_sat_step(BP_MAX_W'(value), 1'b0, W));
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped tagged BTB with per-entry saturating direction counters:
// combinational lookup for IF, one-edge update and mispredict detection for EX.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int ADDR_W  = BP_ADDR_W,
  parameter int CTR_W   = BP_CTR_W,
  parameter int STAT_W  = BP_STAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              flush_all,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] recover_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(bp_ctr_init(CTR_W));

  logic              valid_r  [ENTRIES];
  logic [TAG_W-1:0]  tag_r    [ENTRIES];
  logic [ADDR_W-1:0] target_r [ENTRIES];
  logic [CTR_W-1:0]  ctr_s    [ENTRIES];

  logic [IDX_W-1:0] lookIdx_s;
  logic [TAG_W-1:0] lookTag_s;
  logic [IDX_W-1:0] updIdx_s;
  logic [TAG_W-1:0] updTag_s;
  logic             updHit_s;
  logic             updEn_s;

  assign lookIdx_s = IDX_W'(bp_idx(BP_MAX_W'(if_pc), IDX_W));
  assign lookTag_s = TAG_W'(bp_tag(BP_MAX_W'(if_pc), IDX_W));
  assign updIdx_s  = IDX_W'(bp_idx(BP_MAX_W'(upd_pc), IDX_W));
  assign updTag_s  = TAG_W'(bp_tag(BP_MAX_W'(upd_pc), IDX_W));
  assign updHit_s  = valid_r[updIdx_s] && (tag_r[updIdx_s] == updTag_s);
  assign updEn_s   = upd_valid && !flush_all;

  // IF lookup against current contents; no bypass from a same-cycle update
  always_comb begin
    pred_hit   = valid_r[lookIdx_s] && (tag_r[lookIdx_s] == lookTag_s);
    pred_taken = pred_hit && ctr_s[lookIdx_s][CTR_W-1];
    if (pred_taken) begin
      pred_target = target_r[lookIdx_s];
    end else begin
      pred_target = if_pc + ADDR_W'(32'd4);
    end
  end

  // EX resolution: wrong direction, or taken to a different target
  always_comb begin
    if (upd_valid) begin
      mispredict = (upd_taken != upd_pred_taken) ||
                   (upd_taken && upd_pred_taken && (upd_target != upd_pred_target));
    end else begin
      mispredict = 1'b0;
    end
    if (upd_taken) begin
      recover_pc = upd_target;
    end else begin
      recover_pc = upd_pc + ADDR_W'(32'd4);
    end
  end

  // Tag/target/valid storage; a taken hit rewrites the same tag, so hit and
  // allocate share one write path.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= {ADDR_W{1'b0}};
      end
    end else if (flush_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
      end
    end else if (upd_valid && upd_taken) begin
      valid_r[updIdx_s]  <= 1'b1;
      tag_r[updIdx_s]    <= updTag_s;
      target_r[updIdx_s] <= upd_target;
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : gCtr
    logic sel_s;
    assign sel_s = updEn_s && (updIdx_s == IDX_W'(i));

    branch_target_predictor_sat_counter #(.W(CTR_W)) uCtr (
      .clk       (clk),
      .rst       (rst),
      .load      (sel_s && !updHit_s && upd_taken),
      .loadValue (CTR_INIT),
      .inc       (sel_s && updHit_s && upd_taken),
      .dec       (sel_s && updHit_s && !upd_taken),
      .value     (ctr_s[i])
    );
  end

  // Stats keep counting through flush_all; only rst clears them.
  branch_target_predictor_sat_counter #(.W(STAT_W)) uStatBranches (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .loadValue ({STAT_W{1'b0}}),
    .inc       (upd_valid),
    .dec       (1'b0),
    .value     (stat_branches)
  );

  branch_target_predictor_sat_counter #(.W(STAT_W)) uStatMispredicts (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .loadValue ({STAT_W{1'b0}}),
    .inc       (mispredict),
    .dec       (1'b0),
    .value     (stat_mispredicts)
  );

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench: directed and random branch resolutions compared
// against an array-based behavioural model of the predictor table.
module tb_branch_target_predictor;

  localparam int ENTRIES  = 16;
  localparam int CTR_W    = 2;
  localparam int STAT_W   = 4;
  localparam int CTR_MAX  = (1 << CTR_W) - 1;
  localparam int CTR_HALF = 1 << (CTR_W - 1);
  localparam int STAT_MAX = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       if_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic              flush_all;
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic              upd_pred_taken;
  logic [31:0]       upd_pred_target;
  logic              mispredict;
  logic [31:0]       recover_pc;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  int nChecks = 0;
  int nFails  = 0;

  bit          mValid  [ENTRIES];
  int unsigned mTag    [ENTRIES];
  logic [31:0] mTarget [ENTRIES];
  int          mCtr    [ENTRIES];
  int          mBranches;
  int          mMisp;

  branch_target_predictor #(
    .ENTRIES(ENTRIES), .ADDR_W(32), .CTR_W(CTR_W), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .flush_all(flush_all), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .recover_pc(recover_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  function automatic int unsigned mIdx(input logic [31:0] pc);
    int unsigned p;
    p = pc;
    return (p / 4) % ENTRIES;
  endfunction

  function automatic int unsigned mTagOf(input logic [31:0] pc);
    int unsigned p;
    p = pc;
    return p / (4 * ENTRIES);
  endfunction

  function automatic logic mHit(input logic [31:0] pc);
    return mValid[mIdx(pc)] && (mTag[mIdx(pc)] == mTagOf(pc));
  endfunction

  function automatic logic mPredTaken(input logic [31:0] pc);
    return mHit(pc) && (mCtr[mIdx(pc)] >= CTR_HALF);
  endfunction

  function automatic logic [31:0] mPredTarget(input logic [31:0] pc);
    return mPredTaken(pc) ? mTarget[mIdx(pc)] : pc + 32'd4;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < ENTRIES; i++) begin
      mValid[i] = 1'b0; mTag[i] = 0; mTarget[i] = 32'd0; mCtr[i] = 0;
    end
    mBranches = 0;
    mMisp = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after negedge, check combinational outputs and
  // stats against the model, then advance the model across the posedge.
  task automatic step(input logic v, input logic [31:0] pc, input logic tk,
                      input logic [31:0] tgt, input logic pTk, input logic [31:0] pTgt,
                      input logic fl, input logic rs, input logic [31:0] look);
    logic eMisp;
    int unsigned ui;
    @(negedge clk);
    rst = rs; flush_all = fl; upd_valid = v; upd_pc = pc; upd_taken = tk;
    upd_target = tgt; upd_pred_taken = pTk; upd_pred_target = pTgt; if_pc = look;
    #1;
    check("pred_hit", 32'(pred_hit), 32'(mHit(look)));
    check("pred_taken", 32'(pred_taken), 32'(mPredTaken(look)));
    check("pred_target", pred_target, mPredTarget(look));
    eMisp = v && ((tk != pTk) || (tk && pTk && (tgt != pTgt)));
    check("mispredict", 32'(mispredict), 32'(eMisp));
    check("recover_pc", recover_pc, tk ? tgt : pc + 32'd4);
    check("stat_branches", 32'(stat_branches), 32'(mBranches));
    check("stat_mispredicts", 32'(stat_mispredicts), 32'(mMisp));
    @(posedge clk);
    if (rs) begin
      modelReset();
    end else begin
      if (v) begin
        if (mBranches < STAT_MAX) mBranches++;
        if (eMisp && mMisp < STAT_MAX) mMisp++;
      end
      if (fl) begin
        for (int i = 0; i < ENTRIES; i++) mValid[i] = 1'b0;
      end else if (v) begin
        ui = mIdx(pc);
        if (mHit(pc)) begin
          if (tk) begin
            if (mCtr[ui] < CTR_MAX) mCtr[ui]++;
            mTarget[ui] = tgt;
          end else if (mCtr[ui] > 0) begin
            mCtr[ui]--;
          end
        end else if (tk) begin
          mValid[ui] = 1'b1; mTag[ui] = mTagOf(pc); mTarget[ui] = tgt; mCtr[ui] = CTR_HALF;
        end
      end
    end
  endtask

  task automatic idle(input logic [31:0] look);
    step(1'b0, 32'h0040_1000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, look);
  endtask

  // Resolve pc with the prediction the model says IF would have made.
  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic [31:0] look);
    step(1'b1, pc, tk, tgt, mPredTaken(pc), mPredTarget(pc), 1'b0, 1'b0, look);
  endtask

  initial begin
    logic [31:0] p1, p2, p3, rp, rt, lk;
    logic rtk, rv, rfl, rpt;
    p1 = 32'h0040_0010;
    p2 = 32'h0040_0050;
    p3 = 32'h0040_0200;
    rst = 1'b1; flush_all = 1'b0; upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0;
    upd_target = 32'd0; upd_pred_taken = 1'b0; upd_pred_target = 32'd0; if_pc = p1;
    modelReset();
    repeat (2) @(posedge clk);

    idle(p1);
    step(1'b1, p1, 1'b1, 32'h0040_0100, 1'b0, p1 + 32'd4, 1'b0, 1'b0, p1);
    idle(p1);
    check("alloc_target", pred_target, 32'h0040_0100);
    repeat (3) resolve(p1, 1'b0, 32'd0, p1);
    resolve(p1, 1'b1, 32'h0040_0100, p1);
    idle(p1);
    check("no_underflow_taken", 32'(pred_taken), 32'd0);

    resolve(p2, 1'b1, 32'h0040_0500, p1);
    idle(p1);
    check("alias_evicted", 32'(pred_hit), 32'd0);
    idle(p2);

    step(1'b1, p3, 1'b1, 32'h0040_0600, 1'b0, p3 + 32'd4, 1'b1, 1'b0, p2);
    idle(p2);
    idle(p3);
    step(1'b1, p3, 1'b1, 32'h0040_0700, 1'b0, p3 + 32'd4, 1'b0, 1'b1, p3);
    idle(p3);
    check("rst_stats", 32'(stat_branches), 32'd0);

    for (int n = 0; n < 120; n++) begin
      rp  = 32'h0040_0000 + (32'($urandom_range(0, 47)) << 2);
      rt  = 32'h0041_0000 + (32'($urandom_range(0, 255)) << 2);
      rtk = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 9) < 8);
      rfl = ($urandom_range(0, 15) == 0);
      lk  = ($urandom_range(0, 1) == 1) ? rp : 32'h0040_0000 + (32'($urandom_range(0, 47)) << 2);
      if ($urandom_range(0, 9) < 7) begin
        step(rv, rp, rtk, rt, mPredTaken(rp), mPredTarget(rp), rfl, 1'b0, lk);
      end else begin
        rpt = 1'($urandom_range(0, 1));
        step(rv, rp, rtk, rt, rpt, rpt ? mTarget[mIdx(rp)] : rp + 32'd4, rfl, 1'b0, lk);
      end
    end

    step(1'b0, p1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, p1);
    for (int n = 0; n < 20; n++) begin
      rp = 32'h0040_0000 + (32'($urandom_range(0, 63)) << 2);
      step(1'b1, rp, 1'b1, rp + 32'h100, 1'b0, rp + 32'd4, 1'b0, 1'b0, rp);
    end
    idle(p1);
    #1;
    check("sat_branches", 32'(stat_branches), 32'd15);
    check("sat_mispredicts", 32'(stat_mispredicts), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
